// File: rtl/pr3_pkg.sv
// -----------------------------------------------------------------------------
// pr3_pkg
// Shared definitions for the adc_conditioner front end.
//   FREQ       run rate in Hz; TICKS_DEF is the clk20 cycle count per run
//   WIDTH_DEF  default sample width (signed)
//   FFT_DEF    default log2 of the capture window length
//   acc_width  ACCW = WIDTH + FFT: accumulator width that cannot overflow
//              over one capture window
//   sat        clamps a signed value to the range of a w-bit signed number
// -----------------------------------------------------------------------------
package pr3_pkg;

  localparam int FREQ      = 5000;
  localparam int TICKS_DEF = 20480000 / FREQ;
  localparam int WIDTH_DEF = 14;
  localparam int FFT_DEF   = 11;

  function automatic int acc_width(input int w, input int fft);
    return w + fft;
  endfunction

  // Used for WIDTH+1 -> WIDTH. The argument is carried in 32 bits so one
  // function serves every parameterisation.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x,
                                             input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/adc_conditioner_dc_channel.sv
// -----------------------------------------------------------------------------
// dc_channel
// One antenna: measures the mean over the capture window, then subtracts the
// previous run's mean from every sample, saturates, and tracks clipping.
//   clk20   in   sample clock
//   reset   in   synchronous, active-high
//   sample  in   stage-1 registered raw sample
//   dc_en   in   1: subtract offset, 0: pass raw
//   first   in   sample is n==0 of a run
//   last    in   sample is n==2**FFT-1 (end of capture window)
//   data    out  conditioned sample (registered)
//   clip    out  sticky clip flag of the previous run, updated on first
// -----------------------------------------------------------------------------
module dc_channel
  import pr3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FFT   = FFT_DEF
) (
  input  logic                    clk20,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] sample,
  input  logic                    dc_en,
  input  logic                    first,
  input  logic                    last,
  output logic signed [WIDTH-1:0] data,
  output logic                    clip
);

  localparam int ACCW = acc_width(WIDTH, FFT);

  logic signed [ACCW-1:0]  r_acc;
  logic signed [WIDTH-1:0] r_offset_next;
  logic signed [WIDTH-1:0] r_offset_act;
  logic signed [WIDTH-1:0] r_data;
  logic                    r_sticky;
  logic                    r_clip;

  logic signed [ACCW-1:0]  w_acc_base;
  logic signed [ACCW-1:0]  w_sum;
  logic signed [WIDTH-1:0] w_offset;
  logic signed [WIDTH:0]   w_off_eff;
  logic signed [WIDTH:0]   w_diff;
  logic signed [31:0]      w_sat;
  logic                    w_raw_ext;
  logic                    w_clip_now;

  always_comb begin
    w_acc_base = first ? '0 : r_acc;
    w_sum      = w_acc_base + ACCW'(sample);
    // On sample 0 the offset being promoted is used directly, so the new
    // offset is effective on that very sample even when the window's last
    // sample was the previous cycle.
    w_offset   = first ? r_offset_next : r_offset_act;
    w_off_eff  = dc_en ? (WIDTH+1)'(w_offset) : '0;
    w_diff     = (WIDTH+1)'(sample) - w_off_eff;
    w_sat      = sat(32'(w_diff), WIDTH);
    w_raw_ext  = (sample == {1'b1, {(WIDTH-1){1'b0}}}) ||
                 (sample == {1'b0, {(WIDTH-1){1'b1}}});
    w_clip_now = (w_sat != 32'(w_diff)) || w_raw_ext;
  end

  always_ff @(posedge clk20) begin
    if (reset) begin
      r_acc         <= '0;
      r_offset_next <= '0;
      r_offset_act  <= '0;
      r_data        <= '0;
      r_sticky      <= 1'b0;
      r_clip        <= 1'b0;
    end else begin
      // Keeps summing past the window; only the value at 'last' is used and
      // the accumulator restarts on 'first'.
      r_acc <= w_sum;
      if (last) r_offset_next <= WIDTH'(w_sum >>> FFT);
      if (first) begin
        r_offset_act <= r_offset_next;
        r_clip       <= r_sticky;
      end
      r_sticky <= (first ? 1'b0 : r_sticky) | w_clip_now;
      r_data   <= WIDTH'(w_sat);
    end
  end

  assign data = r_data;
  assign clip = r_clip;

endmodule

// File: rtl/adc_conditioner.sv
// -----------------------------------------------------------------------------
// adc_conditioner
// Sample-domain front end: per-antenna DC removal with saturation, per-run
// clip flags, run-start strobe and run number.
//   clk20         in   20.48 MHz sample clock
//   reset         in   synchronous, active-high
//   sink          in   NSINK raw samples, one per cycle
//   dc_en         in   1: subtract offset, 0: pass raw (offsets still measured)
//   source_start  out  one-cycle pulse aligned with sample 0 of a run
//   source_data   out  NSINK conditioned samples (2-cycle latency)
//   source_clip   out  per-antenna clip flags of the previous run
//   source_run    out  run number, 0 at the first start after reset
// -----------------------------------------------------------------------------
module adc_conditioner
  import pr3_pkg::*;
#(
  parameter int NSINK = 3,
  parameter int WIDTH = WIDTH_DEF,
  parameter int FFT   = FFT_DEF,
  parameter int TICKS = TICKS_DEF
) (
  input  logic                    clk20,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] sink [0:NSINK-1],
  input  logic                    dc_en,
  output logic                    source_start,
  output logic signed [WIDTH-1:0] source_data [0:NSINK-1],
  output logic [NSINK-1:0]        source_clip,
  output logic [15:0]             source_run
);

  localparam int CW  = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int WIN = 2 ** FFT;

  if (TICKS < WIN || TICKS > 65536) begin : g_bad_ticks
    $error("adc_conditioner: TICKS must lie in [2**FFT, 2**16]");
  end

  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_cnt_s1;
  logic                    r_vld_s1;
  logic                    r_dc_en_s1;
  logic signed [WIDTH-1:0] r_sink_s1 [0:NSINK-1];
  logic                    r_start;
  logic                    r_started;
  logic [15:0]             r_run;

  logic                    w_first;
  logic                    w_last;
  logic [NSINK-1:0]        w_clip;

  // Stage 1. r_vld_s1 masks the reset-cleared contents of the stage so that
  // no start is generated in the first cycle after reset.
  always_ff @(posedge clk20) begin
    if (reset) begin
      r_cnt      <= '0;
      r_cnt_s1   <= '0;
      r_vld_s1   <= 1'b0;
      r_dc_en_s1 <= 1'b0;
      for (int i = 0; i < NSINK; i++) r_sink_s1[i] <= '0;
    end else begin
      r_cnt      <= (r_cnt == CW'(TICKS - 1)) ? '0 : r_cnt + CW'(1);
      r_cnt_s1   <= r_cnt;
      r_vld_s1   <= 1'b1;
      r_dc_en_s1 <= dc_en;
      for (int i = 0; i < NSINK; i++) r_sink_s1[i] <= sink[i];
    end
  end

  assign w_first = r_vld_s1 && (r_cnt_s1 == '0);
  assign w_last  = r_vld_s1 && (r_cnt_s1 == CW'(WIN - 1));

  always_ff @(posedge clk20) begin
    if (reset) begin
      r_start   <= 1'b0;
      r_started <= 1'b0;
      r_run     <= '0;
    end else begin
      r_start <= w_first;
      if (w_first) begin
        r_run     <= r_started ? r_run + 16'd1 : 16'd0;
        r_started <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NSINK; g++) begin : g_ch
    dc_channel #(
      .WIDTH (WIDTH),
      .FFT   (FFT)
    ) u_ch (
      .clk20  (clk20),
      .reset  (reset),
      .sample (r_sink_s1[g]),
      .dc_en  (r_dc_en_s1),
      .first  (w_first),
      .last   (w_last),
      .data   (source_data[g]),
      .clip   (w_clip[g])
    );
  end

  assign source_start = r_start;
  assign source_clip  = w_clip;
  assign source_run   = r_run;

endmodule

// File: tb/tb_adc_conditioner.sv
module tb_adc_conditioner;

  localparam int NSINK = 3;
  localparam int WIDTH = 14;
  localparam int FFT   = 4;
  localparam int TICKS = 32;
  localparam int WIN   = 16;
  localparam int SMAX  = 8191;
  localparam int SMIN  = -8192;

  logic                    clk20 = 1'b0;
  logic                    reset = 1'b1;
  logic                    dc_en = 1'b0;
  logic signed [WIDTH-1:0] sink [0:NSINK-1];
  logic                    source_start;
  logic signed [WIDTH-1:0] source_data [0:NSINK-1];
  logic [NSINK-1:0]        source_clip;
  logic [15:0]             source_run;

  always #24 clk20 = ~clk20;

  adc_conditioner #(
    .NSINK (NSINK),
    .WIDTH (WIDTH),
    .FFT   (FFT),
    .TICKS (TICKS)
  ) dut (
    .clk20        (clk20),
    .reset        (reset),
    .sink         (sink),
    .dc_en        (dc_en),
    .source_start (source_start),
    .source_data  (source_data),
    .source_clip  (source_clip),
    .source_run   (source_run)
  );

  typedef struct packed {
    logic [13:0] d0;
    logic [13:0] d1;
    logic [13:0] d2;
    logic        st;
    logic [2:0]  clip;
    logic [15:0] run;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
  endtask

  // Reference model: works per run with plain integer arithmetic.
  int       m_n, m_run;
  int       m_off [3];
  int       m_pend[3];
  int       m_sum [3];
  bit       m_started;
  bit [2:0] m_sticky, m_clip_rep;

  function automatic int clampv(input int x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  function automatic int floor_div(input int s, input int d);
    int r;
    r = s / d;
    if (s < 0 && (s % d) != 0) r = r - 1;
    return r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_run = 0; m_started = 0; m_sticky = '0; m_clip_rep = '0;
    for (int a = 0; a < 3; a++) begin
      m_off[a] = 0; m_pend[a] = 0; m_sum[a] = 0;
    end
  endtask

  task automatic model_sample(input int v[3], input bit en, output exp_t e);
    int o[3];
    int d;
    if (m_n == 0) begin
      m_run      = m_started ? ((m_run + 1) % 65536) : 0;
      m_started  = 1;
      m_clip_rep = m_sticky;
      m_sticky   = '0;
      for (int a = 0; a < 3; a++) begin
        m_off[a] = m_pend[a];
        m_sum[a] = 0;
      end
    end
    for (int a = 0; a < 3; a++) begin
      d    = v[a] - (en ? m_off[a] : 0);
      o[a] = clampv(d);
      if (o[a] != d || v[a] == SMIN || v[a] == SMAX) m_sticky[a] = 1'b1;
      if (m_n < WIN) m_sum[a] += v[a];
      if (m_n == WIN - 1) m_pend[a] = floor_div(m_sum[a], WIN);
    end
    e.d0   = o[0][13:0];
    e.d1   = o[1][13:0];
    e.d2   = o[2][13:0];
    e.st   = (m_n == 0);
    e.clip = m_clip_rep;
    e.run  = m_run[15:0];
    m_n = (m_n + 1) % TICKS;
  endtask

  // One clock: check the outputs of the sample driven two cycles earlier,
  // then drive the next inputs and predict their result.
  task automatic step(input bit rst_i, input bit en_i, input int v0, input int v1, input int v2);
    exp_t e;
    int   v[3];
    @(posedge clk20);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("data0", {18'b0, source_data[0]}, {18'b0, e.d0});
      chk("data1", {18'b0, source_data[1]}, {18'b0, e.d1});
      chk("data2", {18'b0, source_data[2]}, {18'b0, e.d2});
      chk("start", {31'b0, source_start}, {31'b0, e.st});
      chk("clip",  {29'b0, source_clip},  {29'b0, e.clip});
      chk("run",   {16'b0, source_run},   {16'b0, e.run});
    end
    reset   = rst_i;
    dc_en   = en_i;
    sink[0] = WIDTH'(v0);
    sink[1] = WIDTH'(v1);
    sink[2] = WIDTH'(v2);
    if (rst_i) begin
      model_reset();
      for (int i = 0; i < q.size(); i++) q[i] = '0;
      q.push_back('0);
    end else begin
      v = '{v0, v1, v2};
      model_sample(v, en_i, e);
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic run_const(input int k, input int val, input bit en);
    for (int i = 0; i < k; i++) step(1'b0, en, val, val, val);
  endtask

  initial begin
    int b[3];
    int v[3];
    bit en;
    for (int i = 0; i < NSINK; i++) sink[i] = '0;
    model_reset();

    // constant 100 with correction: run 0 = 100, later runs = 0
    do_reset(3);
    run_const(3 * TICKS, 100, 1'b1);

    // window of alternating -1/0, then 50: offset -1, next run 51
    do_reset(3);
    for (int n = 0; n < TICKS; n++) begin
      v[0] = (n < WIN) ? ((n % 2 == 0) ? -1 : 0) : 50;
      step(1'b0, 1'b1, v[0], v[0], v[0]);
    end
    run_const(TICKS + 4, 50, 1'b1);

    // extreme offsets, saturation and clip flag lifetime
    do_reset(3);
    run_const(TICKS, SMIN, 1'b1);
    run_const(TICKS, SMAX, 1'b1);
    run_const(2 * TICKS + 2, 0, 1'b1);

    // dc_en off, then switched on mid run 1
    do_reset(3);
    run_const(TICKS + 10, 100, 1'b0);
    run_const(TICKS + 22, 100, 1'b1);

    // reset at cnt 20 of run 2
    do_reset(3);
    run_const(2 * TICKS + 20, 100, 1'b1);
    do_reset(3);
    run_const(2 * TICKS + 2, 100, 1'b1);

    // randomized runs around random per-antenna biases
    do_reset(3);
    en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 3; a++) b[a] = int'($urandom_range(0, 16000)) - 8000;
      for (int n = 0; n < TICKS; n++) begin
        for (int a = 0; a < 3; a++) begin
          case ($urandom_range(0, 19))
            0:       v[a] = SMIN;
            1:       v[a] = SMAX;
            default: v[a] = clampv(b[a] + int'($urandom_range(0, 400)) - 200);
          endcase
        end
        if ($urandom_range(0, 15) == 0) en = ~en;
        step(1'b0, en, v[0], v[1], v[2]);
      end
    end
    run_const(3, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
